// File: rtl/lif_neuron_layer_seq.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared update datapath sweeps stored membranes.
// Optional refractory counters are enabled with `define REFRACTORY_EN.

module lif_update #(
  parameter int N_STAGE     = 3,
  parameter int N_MEMBRANE  = N_STAGE + 2,
  parameter int N_THRESHOLD = N_MEMBRANE - 1
) (
  input  logic [2**N_STAGE-1:0]         inputs,
  input  logic [2**N_STAGE-1:0]         weights,
  input  logic signed [N_MEMBRANE-1:0]  u,
  input  logic [2:0]                    shift,
  input  logic [N_THRESHOLD-1:0]        threshold,
  input  logic                          hold,
  output logic signed [N_MEMBRANE-1:0]  u_next,
  output logic                          spike
);
  localparam int N_IN = 2**N_STAGE;
  localparam int PW   = N_STAGE + 2;
  // One guard bit above the wider of membrane and psp so the sum never wraps before clamping.
  localparam int AW   = ((N_MEMBRANE > PW) ? N_MEMBRANE : PW) + 1;
  localparam logic signed [AW-1:0] ONE   = AW'(1);
  localparam logic signed [AW-1:0] MAX_U = AW'((2**(N_MEMBRANE-1)) - 1);
  localparam logic signed [AW-1:0] MIN_U = ~MAX_U;

  logic signed [N_MEMBRANE-1:0] dec;
  logic signed [AW-1:0]         psp, dec_x, sum, acc, thr_x, res;

  always_comb begin
    psp = '0;
    for (int i = 0; i < N_IN; i++)
      if (inputs[i] && !hold) psp = weights[i] ? psp + ONE : psp - ONE;
    // u - (u >>> s) stays within range for both signs, so no clamp is needed here.
    dec   = (shift == 3'd0) ? u : u - (u >>> shift);
    dec_x = {{(AW-N_MEMBRANE){dec[N_MEMBRANE-1]}}, dec};
    sum   = dec_x + psp;
    if (sum > MAX_U)      acc = MAX_U;
    else if (sum < MIN_U) acc = MIN_U;
    else                  acc = sum;
    thr_x  = AW'(threshold);
    spike  = !hold && (acc >= thr_x);
    res    = spike ? acc - thr_x : acc;
    u_next = res[N_MEMBRANE-1:0];
  end
endmodule

module lif_neuron_layer_seq #(
  parameter int N_STAGE     = 3,
  parameter int N_MEMBRANE  = N_STAGE + 2,
  parameter int N_THRESHOLD = N_MEMBRANE - 1,
  parameter int N_NEURONS   = 4,
  parameter int IDX_W       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2**N_STAGE-1:0]        inputs,
  input  logic [2:0]                   shift,
  input  logic [N_THRESHOLD-1:0]       threshold,
`ifdef REFRACTORY_EN
  input  logic [1:0]                   refractory,
`endif
  input  logic                         weight_valid,
  input  logic [2**N_STAGE-1:0]        weight_in,
  output logic                         weight_ready,
  output logic [IDX_W-1:0]             neuron_idx,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spikes,
  input  logic [IDX_W-1:0]             mem_sel,
  output logic signed [N_MEMBRANE-1:0] mem_out
);
  localparam int N_IN = 2**N_STAGE;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                            state;
  logic [N_IN-1:0]                       in_q;
  logic [2:0]                            shift_q;
  logic [N_THRESHOLD-1:0]                thr_q;
  logic [N_NEURONS-1:0][N_MEMBRANE-1:0]  mem;
  logic [N_NEURONS-1:0]                  spk_sh, spk_next;
  logic                                  accept, last, hold, fire;
  logic signed [N_MEMBRANE-1:0]          u_cur, u_next;

  assign accept       = (state == S_RUN) && weight_valid;
  assign last         = (neuron_idx == IDX_W'(N_NEURONS - 1));
  assign u_cur        = mem[neuron_idx];
  assign weight_ready = (state == S_RUN);
  assign busy         = (state == S_RUN) || (state == S_DONE);
  assign done         = (state == S_DONE);

  lif_update #(
    .N_STAGE     (N_STAGE),
    .N_MEMBRANE  (N_MEMBRANE),
    .N_THRESHOLD (N_THRESHOLD)
  ) u_upd (
    .inputs    (in_q),
    .weights   (weight_in),
    .u         (u_cur),
    .shift     (shift_q),
    .threshold (thr_q),
    .hold      (hold),
    .u_next    (u_next),
    .spike     (fire)
  );

  always_comb begin
    spk_next             = spk_sh;
    spk_next[neuron_idx] = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      neuron_idx <= '0;
      in_q       <= '0;
      shift_q    <= '0;
      thr_q      <= '0;
      mem        <= '0;
      spk_sh     <= '0;
      spikes     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state      <= S_RUN;
          neuron_idx <= '0;
          in_q       <= inputs;
          shift_q    <= shift;
          thr_q      <= threshold;
          spk_sh     <= '0;
        end
        S_RUN: if (weight_valid) begin
          mem[neuron_idx] <= u_next;
          spk_sh          <= spk_next;
          if (last) begin
            state      <= S_DONE;
            spikes     <= spk_next;
            neuron_idx <= '0;
          end else begin
            neuron_idx <= neuron_idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REFRACTORY_EN
  logic [1:0]                 refr_q;
  logic [N_NEURONS-1:0][1:0]  rcnt;

  assign hold = (rcnt[neuron_idx] != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      refr_q <= '0;
      rcnt   <= '0;
    end else begin
      if ((state == S_IDLE) && start) refr_q <= refractory;
      if (accept) begin
        if (hold)      rcnt[neuron_idx] <= rcnt[neuron_idx] - 2'd1;
        else if (fire) rcnt[neuron_idx] <= refr_q;
      end
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Readout select can only exceed the array when N_NEURONS is not a power of two.
  generate
    if (N_NEURONS == 2**IDX_W) begin : g_rd_full
      assign mem_out = mem[mem_sel];
    end else begin : g_rd_part
      always_comb begin
        mem_out = '0;
        if (int'(mem_sel) < N_NEURONS) mem_out = mem[mem_sel];
      end
    end
  endgenerate
endmodule

// File: tb/tb_lif_neuron_layer_seq.sv
// Scoreboard bench for lif_neuron_layer_seq (N_STAGE=3, N_NEURONS=2, 5-bit membrane).
module tb_lif_neuron_layer_seq;
  logic              clk = 1'b0;
  logic              reset, start, weight_valid;
  logic [7:0]        inputs, weight_in;
  logic [2:0]        shift;
  logic [3:0]        threshold;
  logic              weight_ready, busy, done;
  logic [0:0]        neuron_idx, mem_sel;
  logic [1:0]        spikes;
  logic signed [4:0] mem_out;
`ifdef REFRACTORY_EN
  logic [1:0]        refractory;
`endif

  int tests = 0, fails = 0;
  int done_seen = 0, done_exp = 0;
  logic prev_done = 1'b0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  lif_neuron_layer_seq #(.N_STAGE(3), .N_NEURONS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .inputs       (inputs),
    .shift        (shift),
    .threshold    (threshold),
`ifdef REFRACTORY_EN
    .refractory   (refractory),
`endif
    .weight_valid (weight_valid),
    .weight_in    (weight_in),
    .weight_ready (weight_ready),
    .neuron_idx   (neuron_idx),
    .busy         (busy),
    .done         (done),
    .spikes       (spikes),
    .mem_sel      (mem_sel),
    .mem_out      (mem_out)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_mem(input string nm, input int e0, input int e1);
    mem_sel = 1'b0; #1 chk({nm, " mem0"}, mem_out, e0);
    mem_sel = 1'b1; #1 chk({nm, " mem1"}, mem_out, e1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    if (busy) chk({nm, " idle timeout"}, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // One full timestep with no stalls; expected spike vector goes to the scoreboard.
  task automatic do_step(input string nm, input logic [7:0] in_v, input logic [2:0] sh,
                         input logic [3:0] th, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [1:0] exp_sp);
    exp_q.push_back(exp_sp);
    done_exp++;
    @(negedge clk);
    start = 1'b1; inputs = in_v; shift = sh; threshold = th;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " idx0"}, neuron_idx, 0);
    weight_valid = 1'b1; weight_in = w0;
    @(negedge clk);
    chk({nm, " idx1"}, neuron_idx, 1);
    weight_in = w1;
    @(negedge clk);
    weight_valid = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; weight_valid = 1'b0;
    inputs = '0; weight_in = '0; shift = '0; threshold = '0; mem_sel = '0;
`ifdef REFRACTORY_EN
    refractory = 2'd0;
`endif
    fork
      forever begin
        @(negedge clk);
        if (done) begin
          done_seen++;
          if (prev_done) chk("done width", 2, 1);
          if (exp_q.size() == 0) chk("unexpected done", 1, 0);
          else chk("spikes", spikes, exp_q.pop_front());
        end
        prev_done = done;
      end
    join_none

    do_reset();
    chk("rst busy", busy, 0);
    chk("rst ready", weight_ready, 0);
    chk("rst spikes", spikes, 0);
    chk("rst done", done, 0);
    chk_mem("rst", 0, 0);

    do_step("s1", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("s1", 3, -8);
    do_step("s2", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("s2", 6, -16);
    do_step("s3", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("s3", 9, -16);
    do_step("s4", 8'h00, 3'd1, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("s4", 0, -8);
    do_step("s5", 8'h1F, 3'd0, 4'd5, 8'h00, 8'hFF, 2'b00); chk_mem("s5", -5, -3);
    do_step("s6", 8'h00, 3'd1, 4'd5, 8'h00, 8'h00, 2'b00); chk_mem("s6", -2, -1);

    // Stall three cycles before neuron 1 and poke start while running.
    exp_q.push_back(2'b01);
    done_exp++;
    @(negedge clk);
    start = 1'b1; inputs = 8'hFF; shift = 3'd0; threshold = 4'd0;
    @(negedge clk);
    start = 1'b0; weight_valid = 1'b1; weight_in = 8'hFF;
    @(negedge clk);
    weight_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall idx", neuron_idx, 1);
      chk("stall busy", busy, 1);
      chk_mem("stall", 6, -1);
      start = (k == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall idx end", neuron_idx, 1);
    weight_valid = 1'b1; weight_in = 8'h0F;
    @(negedge clk);
    weight_valid = 1'b0;
    wait_idle("s7");
    chk_mem("s7", 6, -1);

    // Reset after neuron 0 has been written mid-sweep.
    @(negedge clk);
    start = 1'b1; inputs = 8'hFF; shift = 3'd0; threshold = 4'd5;
    @(negedge clk);
    start = 1'b0; weight_valid = 1'b1; weight_in = 8'hFF;
    @(negedge clk);
    weight_valid = 1'b0;
    chk_mem("pre-rst", 9, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst idx", neuron_idx, 0);
    chk("midrst spikes", spikes, 0);
    chk_mem("midrst", 0, 0);

    do_step("s9",  8'hFF, 3'd0, 4'd5,  8'hFF, 8'h00, 2'b01); chk_mem("s9", 3, -8);
    do_step("s10", 8'hFF, 3'd0, 4'd15, 8'hFF, 8'hFF, 2'b00); chk_mem("s10", 11, 0);
    do_step("s11", 8'hFF, 3'd0, 4'd15, 8'hFF, 8'hFF, 2'b01); chk_mem("s11", 0, 8);

`ifdef REFRACTORY_EN
    do_reset();
    refractory = 2'd2;
    do_step("r1", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("r1", 3, -8);
    do_step("r2", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b00); chk_mem("r2", 3, -16);
    do_step("r3", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b00); chk_mem("r3", 3, -16);
    do_step("r4", 8'hFF, 3'd0, 4'd5, 8'hFF, 8'h00, 2'b01); chk_mem("r4", 6, -16);
`endif

    repeat (3) @(negedge clk);
    chk("done count", done_seen, done_exp);
    chk("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lif_neuron_layer_seq.md
Name: lif_neuron_layer_seq

Overview:
- Time-multiplexed layer of N_NEURONS leaky integrate-and-fire neurons sharing one datapath.
- Per timestep: host pulses start, then streams one weight vector per neuron. Block updates each neuron's stored membrane (decay, synaptic sum, clamp, threshold, reset-by-subtraction) and collects a spike vector.
- Sits between input-spike source and next layer; replaces per-neuron combinational instances with stored state.

Parameters:
- N_STAGE, 3, log2 of synapse count; fan-in = 2**N_STAGE
- N_MEMBRANE, N_STAGE+2, signed membrane width
- N_THRESHOLD, N_MEMBRANE-1, unsigned threshold width
- N_NEURONS, 4, neurons in layer (>=1)
- IDX_W, clog2(N_NEURONS) (min 1), neuron index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin timestep; accepted only in IDLE
- inputs  in  2**N_STAGE  input spikes; captured on accepted start
- shift  in  3  decay shift; captured on accepted start
- threshold  in  N_THRESHOLD  firing threshold; captured on accepted start
- weight_valid  in  1  weight_in valid
- weight_in  in  2**N_STAGE  binary weights for neuron neuron_idx (1 = +1, 0 = -1)
- weight_ready  out  1  high in RUN
- neuron_idx  out  IDX_W  neuron currently awaiting weights
- busy  out  1  high in RUN or DONE
- done  out  1  one-cycle pulse; spikes valid
- spikes  out  N_NEURONS  spike vector of last completed timestep
- mem_sel  in  IDX_W  membrane readout select
- mem_out  out  N_MEMBRANE  combinational read of membrane[mem_sel]; 0 if mem_sel >= N_NEURONS

Behaviour:
- Reset, one clock, synchronous, active-high: FSM=IDLE; all membranes=0; spikes=0; done=0; neuron_idx=0; captured regs=0. Reset mid-RUN aborts the sweep and discards partial results.
- FSM states:
  - IDLE --start--> RUN. Captures inputs, shift, threshold; neuron_idx=0.
  - RUN: each cycle with weight_valid&weight_ready updates neuron neuron_idx. Last index -> DONE, else idx+1. weight_valid low stalls with no state change.
  - DONE: done=1 for exactly one cycle; spikes register updated at the DONE transition; -> IDLE.
  - start outside IDLE ignored. Back-to-back: start accepted the cycle after DONE.
  - Throughput: N_NEURONS+2 cycles per timestep minimum.
- Per-neuron update, combinational within the accepting cycle, written at the clock edge:
  - psp = sum over i of (inputs[i] ? (w[i] ? +1 : -1) : 0). Range -(2**N_STAGE)..+(2**N_STAGE), sign-extended to N_MEMBRANE.
  - decay: shift=0 -> u; else u - (u >>> shift), arithmetic shift (rounds toward -inf; u=-3, shift=1 -> -1).
  - acc = saturating signed add(decay, psp), clamped to [-2**(N_MEMBRANE-1), 2**(N_MEMBRANE-1)-1].
  - spike = acc >= signed zero-extended threshold; threshold=0 with acc>=0 spikes.
  - new u = spike ? acc - threshold : acc. Cannot overflow, since acc >= threshold >= 0.
- Spike bits accumulate in a shadow register during RUN; spikes output changes only at DONE.
- mem_out reflects the written value from the cycle after the write.

Optional Feature:
- Macro REFRACTORY_EN.
- Defined:
  - Adds input refractory (2 bits, captured at start) and a 2-bit per-neuron counter (reset 0).
  - On spike, counter loads refractory.
  - While counter != 0 at update: psp forced to 0, spike suppressed, counter decrements.
  - Decay still applied.
- Undefined: no port, no counters; behaviour exactly as above.

Test Plan (N_STAGE=3, N_NEURONS=2, 5-bit membrane):
- reset, then start with inputs=8'hFF, threshold=5, shift=0; weights n0=8'hFF, n1=8'h00 -> n0 acc=8, spike, u=3; n1 u=-8; spikes=2'b01; done pulses one cycle.
- repeat the same timestep -> n0 acc=11, spike, u=6; n1 acc=-16, u=-16. Third step: n1 stays -16 (clamp); spikes=2'b01.
- u0=-16, shift=1, inputs=0 -> u0=-8, no spike. u=-3 equivalent case: shift=1 -> -1.
- weight_valid low for 3 cycles mid-RUN -> idx held, no membrane change; start pulsed during RUN ignored; done exactly once.
- reset asserted in RUN after n0 update -> all membranes 0, spikes 0, FSM IDLE next cycle.
- REFRACTORY_EN, refractory=2, n0 weights 8'hFF, threshold=5 -> spikes on n0 at steps 1 and 4 only; steps 2-3 psp ignored, decay applied.
